pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch stage of the MIPS CPU: owns the program counter, issues word fetches to instruction memory over a req/ready handshake, and delivers fetched instructions with their PC+4 through an IF/ID pipeline register. It consumes branch/jump redirects from decode and forms the next PC with the shared sign-extend, shift-left-2, adder and 2:1 mux utilities. A one-entry skid buffer absorbs a memory response that arrives while decode is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  decode cannot accept a new IF/ID word this cycle
- branch_taken  in  1  redirect to branch target (PC-relative)
- branch_imm  in  16  branch offset in words, signed
- jump  in  1  redirect to jump target; priority over branch_taken
- jump_index  in  26  jump field, signed
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch byte address, word aligned
- imem_ready  in  1  memory returns imem_rdata this cycle (may be same cycle as req)
- imem_rdata  in  32  fetched instruction
- if_valid  out  1  IF/ID register holds a live instruction
- if_instr  out  32  IF/ID instruction
- if_pc_plus4  out  32  IF/ID PC+4 of if_instr

## Operation
- redirect = jump | branch_taken; ignored unless if_valid=1. Refers to the instruction in IF/ID (no delay slot).
- Targets: branch = if_pc_plus4 + (sext16(branch_imm) << 2); jump = sext26(jump_index) << 2, i.e. {4{idx[25]}, idx, 2'b00}. 32-bit wrap, no overflow detection.
- accept = !if_valid | !stall. Redirect has priority over stall: on redirect, if_valid<=0 and the branch instruction is considered consumed.
- FSM states REQ, DISCARD, SKID:
  - REQ: imem_req=1, imem_addr=pc. ready&redirect -> drop data, pc<=target, stay REQ. ready&!redirect&accept -> load IF/ID (if_instr=rdata, if_pc_plus4=pc+4, if_valid=1), pc<=pc+4, stay REQ. ready&!redirect&!accept -> rdata and pc+4 into skid, pc<=pc+4, go SKID. !ready&redirect -> hold addr in req_addr, pc<=target, go DISCARD. !ready&!redirect -> hold.
  - DISCARD: imem_req=1, imem_addr=req_addr (stable until ready). On ready: drop data, go REQ. Further redirects update pc only.
  - SKID: imem_req=0. redirect -> drop skid, pc<=target, go REQ. accept -> skid into IF/ID, if_valid=1, go REQ.
- IF/ID holds its value while stall & if_valid & no load.
- Reset values: pc=RESET_PC, state=REQ, if_valid=0, if_instr=0, if_pc_plus4=0, skid cleared; imem_req=0 in the reset cycle.

## Timing
- Once imem_req=1 it stays high with constant imem_addr until imem_ready (no withdrawal, even on stall or redirect).
- imem_ready in cycle N -> if_valid/if_instr updated at edge ending N; next request to pc+4 in N+1.
- Zero-wait memory with no stalls: one instruction per cycle.
- Redirect in cycle N: first request to target in N+1 (REQ/SKID) or after the discarded response (DISCARD); target instruction in IF/ID no earlier than N+2.
- Redirect and ready in same cycle: response dropped, never reaches IF/ID.
- Reset mid-DISCARD/SKID: outstanding response forgotten; memory must honour reset as well.

## Structure
- Header fetch_defs.vh: state encodings (REQ=2'd0, DISCARD=2'd1, SKID=2'd2), RESET_PC default.
- Sub-module next_pc_sel: combinational target/next-PC selection built from sign_extend, sign_extend_mod, shl_2, adder, mux2_32. FSM, PC, skid and IF/ID registers stay in pc_fetch.

## Test plan
- Reset, ready tied 1, stall 0 -> imem_addr 0,4,8,12 on consecutive cycles; if_pc_plus4 4,8,12 one cycle later.
- if_pc_plus4=0x104, branch_taken=1, branch_imm=16'hFFFE -> next imem_addr 0x0FC, if_valid 0 for one cycle.
- jump=1, branch_taken=1, jump_index=26'h0000040 -> imem_addr 0x100 (jump wins); jump_index=26'h2000000 -> 0xF8000000.
- stall held 3 cycles with ready=1 -> one response in skid, imem_req low, no instruction lost or duplicated after stall drops.
- ready delayed 3 cycles, redirect in cycle 1 -> imem_addr held at old PC until ready, that data never appears, then request to target.
- Reset asserted in SKID -> next cycle if_valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - fetch state encodings, reset PC and next-PC arithmetic helpers
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_DISCARD = 2'd1,
        ST_SKID    = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] sign_extend(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] sign_extend_mod(input logic [25:0] v);
        return {{6{v[25]}}, v};
    endfunction

    function automatic logic [31:0] shl_2(input logic [31:0] v);
        return {v[29:0], 2'b00};
    endfunction

    function automatic logic [31:0] adder(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

    function automatic logic [31:0] mux2_32(input logic sel, input logic [31:0] a,
                                            input logic [31:0] b);
        return sel ? b : a;
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - instruction memory request/response handshake bundle
interface pc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_fetch_next_pc_sel.sv
// rtl/pc_fetch_next_pc_sel.sv - sequential PC increment and branch/jump target selection
module pc_fetch_next_pc_sel
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] if_pc_plus4_i,
    input  logic [15:0] branch_imm_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] target_o
);

    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;

    // Branch is relative to the PC+4 of the instruction sitting in IF/ID; jump wins over branch.
    always_comb begin
        branch_tgt = adder(if_pc_plus4_i, shl_2(sign_extend(branch_imm_i)));
        jump_tgt   = shl_2(sign_extend_mod(jump_index_i));
        target_o   = mux2_32(jump_i, branch_tgt, jump_tgt);
        pc_plus4_o = adder(pc_i, 32'd4);
    end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - MIPS fetch stage: PC, imem handshake, skid buffer and IF/ID register
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [15:0]   branch_imm,
    input  logic          jump,
    input  logic [25:0]   jump_index,
    pc_fetch_if.master    mem,
    output logic          if_valid,
    output logic [31:0]   if_instr,
    output logic [31:0]   if_pc_plus4
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  req_addr_q;
    logic [31:0]  skid_instr_q;
    logic [31:0]  skid_pc4_q;
    logic         if_valid_q;
    logic [31:0]  if_instr_q;
    logic [31:0]  if_pc4_q;

    logic [31:0]  pc_plus4;
    logic [31:0]  target;
    logic         redirect;
    logic         accept;

    pc_fetch_next_pc_sel u_next_pc_sel (
        .pc_i          (pc_q),
        .if_pc_plus4_i (if_pc4_q),
        .branch_imm_i  (branch_imm),
        .jump_i        (jump),
        .jump_index_i  (jump_index),
        .pc_plus4_o    (pc_plus4),
        .target_o      (target)
    );

    // Redirects only count for a live IF/ID instruction; decode takes IF/ID when empty or unstalled.
    always_comb begin
        redirect = if_valid_q & (jump | branch_taken);
        accept   = ~if_valid_q | ~stall;
    end

    // Request is held (address frozen) until ready; SKID stops fetching until decode drains it.
    always_comb begin
        mem.imem_req  = ~reset & (state_q != ST_SKID);
        mem.imem_addr = (state_q == ST_DISCARD) ? req_addr_q : pc_q;
    end

    // Fetch FSM together with PC, skid entry and IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            skid_instr_q <= 32'd0;
            skid_pc4_q   <= 32'd0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= 32'd0;
            if_pc4_q     <= 32'd0;
        end else begin
            // IF/ID empties when consumed or flushed, unless a load below refills it.
            if (redirect || accept) begin
                if_valid_q <= 1'b0;
            end
            case (state_q)
                ST_REQ: begin
                    if (mem.imem_ready) begin
                        if (redirect) begin
                            pc_q <= target;
                        end else if (accept) begin
                            if_valid_q <= 1'b1;
                            if_instr_q <= mem.imem_rdata;
                            if_pc4_q   <= pc_plus4;
                            pc_q       <= pc_plus4;
                        end else begin
                            skid_instr_q <= mem.imem_rdata;
                            skid_pc4_q   <= pc_plus4;
                            pc_q         <= pc_plus4;
                            state_q      <= ST_SKID;
                        end
                    end else if (redirect) begin
                        req_addr_q <= pc_q;
                        pc_q       <= target;
                        state_q    <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (redirect) begin
                        pc_q <= target;
                    end
                    if (mem.imem_ready) begin
                        state_q <= ST_REQ;
                    end
                end
                ST_SKID: begin
                    if (redirect) begin
                        pc_q    <= target;
                        state_q <= ST_REQ;
                    end else if (accept) begin
                        if_valid_q <= 1'b1;
                        if_instr_q <= skid_instr_q;
                        if_pc4_q   <= skid_pc4_q;
                        state_q    <= ST_REQ;
                    end
                end
                default: state_q <= ST_REQ;
            endcase
        end
    end

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc_plus4 = if_pc4_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - table-driven self-checking bench for pc_fetch
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_index;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] INSTR_KEY = 32'hDEAD_0000;

    pc_fetch_if ifc ();

    // Memory returns a word derived from its address so misplaced or duplicated words show up.
    assign ifc.imem_rdata = ifc.imem_addr ^ INSTR_KEY;

    pc_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_index   (jump_index),
        .mem          (ifc),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc_plus4  (if_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        br;
        logic [15:0] imm;
        logic        jmp;
        logic [25:0] idx;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t tv [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        // stall ready br imm jmp idx | req addr valid pc4 (outputs seen during that cycle)
        tv[0]  = '{0, 1, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_0000, 0, 32'h0};
        tv[1]  = '{0, 1, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_0004, 1, 32'h0000_0004};
        tv[2]  = '{0, 1, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_0008, 1, 32'h0000_0008};
        tv[3]  = '{0, 1, 1, 16'h0000, 1, 26'h0000040, 1, 32'h0000_000C, 1, 32'h0000_000C};
        tv[4]  = '{0, 1, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_0100, 0, 32'h0};
        tv[5]  = '{0, 1, 1, 16'hFFFE, 0, 26'h0,       1, 32'h0000_0104, 1, 32'h0000_0104};
        tv[6]  = '{0, 1, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_00FC, 0, 32'h0};
        tv[7]  = '{0, 1, 0, 16'h0000, 1, 26'h2000000, 1, 32'h0000_0100, 1, 32'h0000_0100};
        tv[8]  = '{0, 1, 0, 16'h0000, 0, 26'h0,       1, 32'hF800_0000, 0, 32'h0};
        tv[9]  = '{1, 1, 0, 16'h0000, 0, 26'h0,       1, 32'hF800_0004, 1, 32'hF800_0004};
        tv[10] = '{1, 1, 0, 16'h0000, 0, 26'h0,       0, 32'hF800_0008, 1, 32'hF800_0004};
        tv[11] = '{1, 1, 0, 16'h0000, 0, 26'h0,       0, 32'hF800_0008, 1, 32'hF800_0004};
        tv[12] = '{0, 1, 0, 16'h0000, 0, 26'h0,       0, 32'hF800_0008, 1, 32'hF800_0004};
        tv[13] = '{0, 1, 0, 16'h0000, 0, 26'h0,       1, 32'hF800_0008, 1, 32'hF800_0008};
        tv[14] = '{0, 0, 0, 16'h0000, 1, 26'h0000010, 1, 32'hF800_000C, 1, 32'hF800_000C};
        tv[15] = '{0, 0, 0, 16'h0000, 0, 26'h0,       1, 32'hF800_000C, 0, 32'h0};
        tv[16] = '{0, 0, 0, 16'h0000, 0, 26'h0,       1, 32'hF800_000C, 0, 32'h0};
        tv[17] = '{0, 1, 0, 16'h0000, 0, 26'h0,       1, 32'hF800_000C, 0, 32'h0};
        tv[18] = '{0, 1, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_0040, 0, 32'h0};
        tv[19] = '{0, 0, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_0044, 1, 32'h0000_0044};
        tv[20] = '{0, 1, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_0044, 0, 32'h0};
        tv[21] = '{1, 0, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_0048, 1, 32'h0000_0048};
        tv[22] = '{1, 1, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_0048, 1, 32'h0000_0048};
        tv[23] = '{1, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0000_004C, 1, 32'h0000_0048};

        reset          = 1'b1;
        stall          = 1'b0;
        branch_taken   = 1'b0;
        branch_imm     = 16'h0;
        jump           = 1'b0;
        jump_index     = 26'h0;
        ifc.imem_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req", {31'd0, ifc.imem_req}, 32'd0);
        chk("reset_valid", {31'd0, if_valid}, 32'd0);
        chk("reset_instr", if_instr, 32'd0);
        chk("reset_pc4", if_pc_plus4, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            stall          = tv[i].stall;
            ifc.imem_ready = tv[i].ready;
            branch_taken   = tv[i].br;
            branch_imm     = tv[i].imm;
            jump           = tv[i].jmp;
            jump_index     = tv[i].idx;
            #1;
            chk($sformatf("v%0d_req", i), {31'd0, ifc.imem_req}, {31'd0, tv[i].e_req});
            chk($sformatf("v%0d_addr", i), ifc.imem_addr, tv[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, tv[i].e_valid});
            if (tv[i].e_valid) begin
                chk($sformatf("v%0d_pc4", i), if_pc_plus4, tv[i].e_pc4);
                chk($sformatf("v%0d_instr", i), if_instr, (tv[i].e_pc4 - 32'd4) ^ INSTR_KEY);
            end
        end

        // Reset while parked in SKID: the buffered word must be forgotten.
        reset = 1'b1;
        #1;
        chk("skid_reset_req", {31'd0, ifc.imem_req}, 32'd0);
        @(negedge clk);
        reset          = 1'b0;
        stall          = 1'b0;
        ifc.imem_ready = 1'b0;
        #1;
        chk("skid_reset_valid", {31'd0, if_valid}, 32'd0);
        chk("skid_reset_addr", ifc.imem_addr, 32'h0000_0000);
        chk("skid_reset_req_after", {31'd0, ifc.imem_req}, 32'd1);

        // First fetch after reset delivers address 0.
        ifc.imem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("post_reset_valid", {31'd0, if_valid}, 32'd1);
        chk("post_reset_pc4", if_pc_plus4, 32'h0000_0004);
        chk("post_reset_addr", ifc.imem_addr, 32'h0000_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
